// File: rtl/speed_control.sv
// Front-panel input stage: synchronises and debounces four active-low pushbuttons and
// keeps a saturating 3-bit speed select for clockdiv.
module speed_control #(
   parameter int unsigned DEBOUNCE_CYCLES = 400000,
   parameter int unsigned CNT_W           = 19,
   parameter logic [2:0]  RESET_SELECT    = 3'd0
) (
   input  logic       CLOCK_40,
   input  logic       reset_n,
   input  logic       btn_step_n,
   input  logic       btn_multi_n,
   input  logic       btn_faster_n,
   input  logic       btn_slower_n,
   output logic [2:0] select,
   output logic       trigger,
   output logic       multitrigger,
   output logic       speed_changed
);

   localparam int unsigned NUM_BTN = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 ||
       (longint'(DEBOUNCE_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_param_check
      $error("speed_control: DEBOUNCE_CYCLES must be >= 1 and CNT_W must hold DEBOUNCE_CYCLES-1");
   end

   // Channel order: 0 step, 1 multi, 2 faster, 3 slower.
   logic [NUM_BTN-1:0] w_raw;
   logic [NUM_BTN-1:0] r_sync1;
   logic [NUM_BTN-1:0] r_sync2;
   logic [NUM_BTN-1:0] r_db;
   logic [NUM_BTN-1:0] w_db_next;
   logic [NUM_BTN-1:0] w_press;
   logic [CNT_W-1:0]   r_cnt      [NUM_BTN];
   logic [CNT_W-1:0]   w_cnt_next [NUM_BTN];

   logic [2:0] r_select;
   logic [2:0] w_select_next;
   logic       r_speed_changed;

   assign w_raw = {btn_slower_n, btn_faster_n, btn_multi_n, btn_step_n};

   always_ff @(posedge CLOCK_40 or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Any cycle of agreement clears the count, so only an unbroken run of
   // DEBOUNCE_CYCLES disagreeing samples moves the debounced state.
   always_comb begin
      w_db_next = r_db;
      for (int i = 0; i < NUM_BTN; i++) begin
         w_cnt_next[i] = '0;
         if (r_sync2[i] != r_db[i]) begin
            if (r_cnt[i] == CNT_MAX) begin
               w_db_next[i] = r_sync2[i];
            end else begin
               w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_40 or negedge reset_n) begin
      if (!reset_n) begin
         r_db <= '1;
         for (int i = 0; i < NUM_BTN; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_db <= w_db_next;
         for (int i = 0; i < NUM_BTN; i++) begin
            r_cnt[i] <= w_cnt_next[i];
         end
      end
   end

   // Press is taken from the debounce next-state so select moves on the same edge.
   assign w_press = r_db & ~w_db_next;

   always_comb begin
      w_select_next = r_select;
      case ({w_press[2], w_press[3]})
         2'b10: if (r_select != 3'd7) w_select_next = r_select + 3'd1;
         2'b01: if (r_select != 3'd0) w_select_next = r_select - 3'd1;
         default: w_select_next = r_select;
      endcase
   end

   always_ff @(posedge CLOCK_40 or negedge reset_n) begin
      if (!reset_n) begin
         r_select        <= RESET_SELECT;
         r_speed_changed <= 1'b0;
      end else begin
         r_select        <= w_select_next;
         r_speed_changed <= (w_select_next != r_select);
      end
   end

   assign select        = r_select;
   assign trigger       = ~r_db[0];
   assign multitrigger  = ~r_db[1];
   assign speed_changed = r_speed_changed;

endmodule

// File: tb/tb_speed_control.sv
// Directed and randomised bench for speed_control against a sample-history reference model.
module tb_speed_control;

   localparam int unsigned D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       step_n = 1'b1;
   logic       multi_n = 1'b1;
   logic       faster_n = 1'b1;
   logic       slower_n = 1'b1;
   logic [2:0] select;
   logic       trigger;
   logic       multitrigger;
   logic       speed_changed;

   int n_cmp = 0;
   int n_err = 0;
   int n_pulse = 0;

   // Reference model: debounced level per button, raw sample history, select value.
   logic [3:0]  m_db;
   logic [15:0] m_hist [4];
   int          m_sel;
   logic        m_sc;

   speed_control #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3),
      .RESET_SELECT   (3'd0)
   ) dut (
      .CLOCK_40     (clk),
      .reset_n      (rst_n),
      .btn_step_n   (step_n),
      .btn_multi_n  (multi_n),
      .btn_faster_n (faster_n),
      .btn_slower_n (slower_n),
      .select       (select),
      .trigger      (trigger),
      .multitrigger (multitrigger),
      .speed_changed(speed_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_db = 4'hF;
      for (int b = 0; b < 4; b++) m_hist[b] = '1;
      m_sel = 0;
      m_sc = 1'b0;
   endfunction

   // A button's debounced level flips once the D samples that have cleared the
   // two-stage synchroniser all disagree with it.
   function automatic void model_clock(input logic [3:0] raw);
      logic [3:0] nxt;
      logic       stable;
      logic       pf;
      logic       ps;
      int         old;
      nxt = m_db;
      for (int b = 0; b < 4; b++) begin
         m_hist[b] = {m_hist[b][14:0], raw[b]};
         stable = 1'b1;
         for (int k = 2; k <= int'(D) + 1; k++) begin
            if (m_hist[b][k] == m_db[b]) stable = 1'b0;
         end
         if (stable) nxt[b] = ~m_db[b];
      end
      pf = m_db[2] & ~nxt[2];
      ps = m_db[3] & ~nxt[3];
      old = m_sel;
      if (pf && !ps && m_sel < 7) m_sel = m_sel + 1;
      else if (ps && !pf && m_sel > 0) m_sel = m_sel - 1;
      m_sc = (m_sel != old);
      m_db = nxt;
   endfunction

   task automatic check_all();
      check("select", {5'd0, select}, 8'(m_sel));
      check("trigger", {7'd0, trigger}, {7'd0, !m_db[0]});
      check("multitrigger", {7'd0, multitrigger}, {7'd0, !m_db[1]});
      check("speed_changed", {7'd0, speed_changed}, {7'd0, m_sc});
   endtask

   // raw bit order: {slower, faster, multi, step}; called between posedges.
   task automatic step(input logic [3:0] raw, input logic rst);
      {slower_n, faster_n, multi_n, step_n} = raw;
      rst_n = rst;
      if (!rst) model_reset();
      @(posedge clk);
      if (rst) model_clock(raw);
      else model_reset();
      @(negedge clk);
      if (speed_changed) n_pulse++;
      check_all();
   endtask

   task automatic press(input logic [3:0] mask);
      for (int i = 0; i < int'(D) + 3; i++) step(~mask, 1'b1);
      for (int i = 0; i < int'(D) + 3; i++) step(4'hF, 1'b1);
   endtask

   initial begin
      logic [3:0] cur;
      int         len;

      // Reset is asynchronous: outputs must settle before any posedge.
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_select", {5'd0, select}, 8'd0);
      check("rst_trigger", {7'd0, trigger}, 8'd0);
      check("rst_multitrigger", {7'd0, multitrigger}, 8'd0);
      check("rst_speed_changed", {7'd0, speed_changed}, 8'd0);
      step(4'hF, 1'b0);
      step(4'hF, 1'b0);
      for (int i = 0; i < 4; i++) step(4'hF, 1'b1);

      // Clean step press at cycle 0, release at cycle 20.
      for (int c = 1; c <= 30; c++) begin
         step((c <= 20) ? 4'b1110 : 4'b1111, 1'b1);
         if (c == 5) check("press_trigger_c5", {7'd0, trigger}, 8'd0);
         if (c == 6) check("press_trigger_c6", {7'd0, trigger}, 8'd1);
         if (c == 25) check("release_trigger_c25", {7'd0, trigger}, 8'd1);
         if (c == 26) check("release_trigger_c26", {7'd0, trigger}, 8'd0);
      end

      // Bounce on multi: low 3, high 1, then low held.
      for (int c = 1; c <= 12; c++) begin
         step((c == 4) ? 4'b1111 : 4'b1101, 1'b1);
         if (c < 10) check("bounce_multi_early", {7'd0, multitrigger}, 8'd0);
         if (c == 10) check("bounce_multi_c10", {7'd0, multitrigger}, 8'd1);
      end
      for (int i = 0; i < int'(D) + 4; i++) step(4'hF, 1'b1);

      // Nine faster presses saturate at 7, nine slower presses back to 0.
      n_pulse = 0;
      for (int i = 0; i < 9; i++) press(4'b0100);
      check("faster_pulses", 8'(n_pulse), 8'd7);
      check("faster_select", {5'd0, select}, 8'd7);
      n_pulse = 0;
      for (int i = 0; i < 9; i++) press(4'b1000);
      check("slower_pulses", 8'(n_pulse), 8'd7);
      check("slower_select", {5'd0, select}, 8'd0);

      // Simultaneous faster+slower at select=3.
      for (int i = 0; i < 3; i++) press(4'b0100);
      n_pulse = 0;
      press(4'b1100);
      check("simul_select", {5'd0, select}, 8'd3);
      check("simul_pulses", 8'(n_pulse), 8'd0);

      // Reset mid-debounce with faster held; held button counts as a new press.
      for (int i = 0; i < 4; i++) step(4'b1011, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("middb_rst_select", {5'd0, select}, 8'd0);
      step(4'b1011, 1'b0);
      step(4'b1011, 1'b0);
      n_pulse = 0;
      for (int c = 1; c <= 10; c++) begin
         step(4'b1011, 1'b1);
         if (c == 5) check("held_select_c5", {5'd0, select}, 8'd0);
         if (c == 6) check("held_select_c6", {5'd0, select}, 8'd1);
      end
      check("held_pulses", 8'(n_pulse), 8'd1);
      for (int i = 0; i < int'(D) + 4; i++) step(4'hF, 1'b1);

      // Random segments: mixed glitches and stable holds, occasional reset.
      for (int seg = 0; seg < 700; seg++) begin
         cur = 4'($urandom);
         len = $urandom_range(1, 2 * int'(D) + 3);
         if ($urandom_range(0, 59) == 0) begin
            step(cur, 1'b0);
         end
         for (int i = 0; i < len; i++) step(cur, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
